// File: rtl/wb_i2c_pkg.sv
// Shared constants for the Wishbone I2C CSR block: register map, bit positions
// and the position of the channel field inside the word address.
package wb_i2c_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_TXDATA = 3'd2;
  localparam logic [2:0] REG_RXDATA = 3'd3;
  localparam logic [2:0] REG_IRQ_EN = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_RW    = 2;

  localparam int ST_BUSY = 0;
  localparam int ST_ACK  = 1;
  localparam int ST_RDY  = 2;
  localparam int ST_ERR  = 3;
  localparam int ST_OVR  = 4;

  localparam int CH_OFS = 3;

endpackage

// File: rtl/wb_i2c_chan_regs.sv
// One channel's register file: CTRL/TXDATA/RXDATA/IRQ_EN, sticky flags with
// hardware-set-wins priority, command pulses and the channel's irq term.
module wb_i2c_chan_regs
  import wb_i2c_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [2:0]        reg_idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              busy,
  input  logic              ack,
  input  logic              rd_valid,
  input  logic              err,
  input  logic [DATA_W-1:0] rd_data,
  output logic              start,
  output logic              stop,
  output logic              rw,
  output logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rdata,
  output logic              irq_term
);

  logic              start_r, stop_r, rw_r;
  logic [DATA_W-1:0] tx_r, rx_r;
  logic [2:0]        irq_en_r;
  logic              rdy_r, err_r, ovr_r;

  logic              wr_ctrl_s, wr_stat_s, wr_tx_s, wr_ien_s, rd_rx_s, start_req_s;
  logic              rdy_nxt_s, err_nxt_s, ovr_nxt_s;
  logic [4:0]        status_s;

  assign wr_ctrl_s   = wr_en & (reg_idx == REG_CTRL);
  assign wr_stat_s   = wr_en & (reg_idx == REG_STATUS);
  assign wr_tx_s     = wr_en & (reg_idx == REG_TXDATA);
  assign wr_ien_s    = wr_en & (reg_idx == REG_IRQ_EN);
  assign rd_rx_s     = rd_en & (reg_idx == REG_RXDATA);
  assign start_req_s = wr_ctrl_s & wdata[CTRL_START];

  // A hardware event in the same cycle as a software clear keeps the flag set.
  assign rdy_nxt_s = rd_valid | (rdy_r & ~(rd_rx_s | (wr_stat_s & wdata[ST_RDY])));
  assign err_nxt_s = err | (err_r & ~(wr_stat_s & wdata[ST_ERR]));
  assign ovr_nxt_s = (rd_valid & rdy_r) | (start_req_s & busy) |
                     (ovr_r & ~(wr_stat_s & wdata[ST_OVR]));

  // Assemble the STATUS view from live engine levels and sticky flags.
  always_comb begin
    status_s          = 5'b0_0000;
    status_s[ST_BUSY] = busy;
    status_s[ST_ACK]  = ack;
    status_s[ST_RDY]  = rdy_r;
    status_s[ST_ERR]  = err_r;
    status_s[ST_OVR]  = ovr_r;
  end

  // Register read mux; values are pre-clear because they come from state.
  always_comb begin
    rdata = {DATA_W{1'b0}};
    case (reg_idx)
      REG_CTRL:   rdata = {{(DATA_W-3){1'b0}}, rw_r, 2'b00};
      REG_STATUS: rdata = {{(DATA_W-5){1'b0}}, status_s};
      REG_TXDATA: rdata = tx_r;
      REG_RXDATA: rdata = rx_r;
      REG_IRQ_EN: rdata = {{(DATA_W-3){1'b0}}, irq_en_r};
      default:    rdata = {DATA_W{1'b0}};
    endcase
  end

  // Channel state and one-cycle command pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r  <= 1'b0;
      stop_r   <= 1'b0;
      rw_r     <= 1'b0;
      tx_r     <= {DATA_W{1'b0}};
      rx_r     <= {DATA_W{1'b0}};
      irq_en_r <= 3'b000;
      rdy_r    <= 1'b0;
      err_r    <= 1'b0;
      ovr_r    <= 1'b0;
    end else begin
      start_r <= start_req_s & ~busy;
      stop_r  <= wr_ctrl_s & wdata[CTRL_STOP];
      if (wr_ctrl_s) rw_r <= wdata[CTRL_RW];
      if (wr_tx_s)   tx_r <= wdata;
      if (rd_valid)  rx_r <= rd_data;
      if (wr_ien_s)  irq_en_r <= wdata[2:0];
      rdy_r <= rdy_nxt_s;
      err_r <= err_nxt_s;
      ovr_r <= ovr_nxt_s;
    end
  end

  assign start    = start_r;
  assign stop     = stop_r;
  assign rw       = rw_r;
  assign tx_data  = tx_r;
  assign irq_term = |({ovr_r, err_r, rdy_r} & irq_en_r);

endmodule

// File: rtl/wb_i2c_csr.sv
// Wishbone classic CSR slave for NUM_CH I2C master channels: address decode,
// single-cycle ack/err, registered read data and the combined interrupt.
module wb_i2c_csr
  import wb_i2c_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_data,
  output logic [DATA_W-1:0]        o_wb_data,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic [NUM_CH-1:0]        o_start,
  output logic [NUM_CH-1:0]        o_stop,
  output logic [NUM_CH-1:0]        o_rw,
  output logic [NUM_CH*DATA_W-1:0] o_tx_data,
  input  logic [NUM_CH-1:0]        i_busy,
  input  logic [NUM_CH-1:0]        i_ack,
  input  logic [NUM_CH-1:0]        i_rd_valid,
  input  logic [NUM_CH-1:0]        i_err,
  input  logic [NUM_CH*DATA_W-1:0] i_rd_data,
  output logic                     o_irq
);

  localparam int CH_W = ADDR_W - CH_OFS;

  logic              req_s, valid_s;
  logic [CH_W-1:0]   ch_idx_s;
  logic [2:0]        reg_idx_s;
  logic [NUM_CH-1:0] ch_sel_s, irq_term_s;
  logic [DATA_W-1:0] ch_rdata_s [NUM_CH];
  logic [DATA_W-1:0] rd_mux_s;
  logic              ack_r, err_r, irq_r;
  logic [DATA_W-1:0] rdata_r;

  // Masking with the current ack/err forbids a second ack while stb lingers.
  assign req_s     = i_wb_cyc & i_wb_stb & ~ack_r & ~err_r;
  assign reg_idx_s = i_wb_addr[CH_OFS-1:0];
  assign ch_idx_s  = i_wb_addr[ADDR_W-1:CH_OFS];
  assign valid_s   = |ch_sel_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_sel_s[g] = (ch_idx_s == CH_W'(g));

    wb_i2c_chan_regs #(.DATA_W(DATA_W)) u_regs (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (req_s & i_wb_we & ch_sel_s[g]),
      .rd_en    (req_s & ~i_wb_we & ch_sel_s[g]),
      .reg_idx  (reg_idx_s),
      .wdata    (i_wb_data),
      .busy     (i_busy[g]),
      .ack      (i_ack[g]),
      .rd_valid (i_rd_valid[g]),
      .err      (i_err[g]),
      .rd_data  (i_rd_data[g*DATA_W +: DATA_W]),
      .start    (o_start[g]),
      .stop     (o_stop[g]),
      .rw       (o_rw[g]),
      .tx_data  (o_tx_data[g*DATA_W +: DATA_W]),
      .rdata    (ch_rdata_s[g]),
      .irq_term (irq_term_s[g])
    );
  end

  // AND-OR channel select; at most one ch_sel_s bit is set.
  always_comb begin
    rd_mux_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      rd_mux_s = rd_mux_s | (ch_rdata_s[k] & {DATA_W{ch_sel_s[k]}});
    end
  end

  // Bus response and interrupt registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
      irq_r   <= 1'b0;
    end else begin
      ack_r   <= req_s & valid_s;
      err_r   <= req_s & ~valid_s;
      rdata_r <= (req_s & valid_s & ~i_wb_we) ? rd_mux_s : {DATA_W{1'b0}};
      irq_r   <= |irq_term_s;
    end
  end

  assign o_wb_ack  = ack_r;
  assign o_wb_err  = err_r;
  assign o_wb_data = rdata_r;
  assign o_irq     = irq_r;

endmodule
